// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// RV32 width codes, FSM state encodings, byte-enable constants and lane helpers.
package mem_access_unit_pkg;

  // RV32 load/store width and sign codes carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Byte-enable patterns
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Command fields kept for the duration of an access
  typedef struct packed {
    logic       load;
    logic [2:0] funct3;
    logic [1:0] offset;
  } cmd_t;

  // True when the access must be aborted before reaching the bus: unaligned
  // half/word, or a width code that does not exist for this direction
  // (unsigned variants only make sense for loads).
  function automatic logic access_bad(input logic store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = |off;
      F3_BU:   bad = store;
      F3_HU:   bad = store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Lane mask for a store of the given width at the given byte offset
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_BYTE0 << off;
      2'b01:   be = off[1] ? BE_HI_HALF : BE_LO_HALF;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across every lane it could target
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the read
// word and sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane[offset];
  assign sel_half = offset[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  // Extend the selected field; full word passes straight through
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   result = {24'b0, sel_byte};
      F3_H:    result = {{16{sel_half[15]}}, sel_half};
      F3_HU:   result = {16'b0, sel_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. One load/store per start strobe:
// IDLE -> ACCESS -> DONE -> IDLE, or IDLE -> DONE for aborted/no-op commands.
// Stores are lane-formatted onto the bus; loads are extended into load_data,
// which holds its value until the next successful load.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5   // must satisfy 2**CNT_W > TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  mem_access_unit_if.master dmem
);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  cmd_t             cmd_reg;

  logic        accept;
  logic        dir_ok;
  logic        bad;
  logic        issue;
  logic        ready_hit;
  logic        timeout_hit;
  logic [31:0] load_ext;

  assign accept      = (state_reg == ST_IDLE) && start;
  assign dir_ok      = is_load ^ is_store;
  assign bad         = access_bad(is_store, funct3, addr[1:0]);
  assign issue       = accept && dir_ok && !bad;
  assign ready_hit   = (state_reg == ST_ACCESS) && dmem.dmem_ready;
  assign timeout_hit = (state_reg == ST_ACCESS) && !dmem.dmem_ready &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign busy        = (state_reg != ST_IDLE);

  // Sequencing, wait counter and completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      cmd_reg      <= '0;
      done         <= 1'b0;
      misaligned   <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            wait_cnt_reg <= '0;
            if (dir_ok) begin
              cmd_reg.load   <= is_load;
              cmd_reg.funct3 <= funct3;
              cmd_reg.offset <= addr[1:0];
            end
            if (issue) begin
              state_reg <= ST_ACCESS;
            end else begin
              // Aborted or no-op command completes without touching the bus
              state_reg  <= ST_DONE;
              done       <= 1'b1;
              misaligned <= dir_ok && bad;
            end
          end
        end
        ST_ACCESS: begin
          if (ready_hit) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end else if (timeout_hit) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
            bus_err   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          state_reg  <= ST_IDLE;
          done       <= 1'b0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: begin
          state_reg  <= ST_IDLE;
          done       <= 1'b0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
      endcase
    end
  end

  // Registered bus outputs: set up on issue, held until ready or timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
    end else if (issue) begin
      dmem.dmem_req   <= 1'b1;
      dmem.dmem_we    <= is_store;
      dmem.dmem_addr  <= {addr[31:2], 2'b00};
      dmem.dmem_be    <= is_store ? store_be(funct3, addr[1:0]) : BE_ALL;
      dmem.dmem_wdata <= is_store ? store_lanes(funct3, wdata) : '0;
    end else if (ready_hit || timeout_hit) begin
      dmem.dmem_req <= 1'b0;
      dmem.dmem_we  <= 1'b0;
    end
  end

  // Capture the extended load result when the bus completes a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_data <= '0;
    end else if (ready_hit && cmd_reg.load) begin
      load_data <= load_ext;
    end
  end

  mem_load_align u_load_align (
    .rdata  (dmem.dmem_rdata),
    .offset (cmd_reg.offset),
    .funct3 (cmd_reg.funct3),
    .result (load_ext)
  );

endmodule
